morse_tx: RTL

- Morse code transmitter. Takes one letter as a symbol pattern and blinks `lightOn` with standard dot/dash/gap timing.
- Pairs with the board-level light/game logic: the upstream switch/key logic issues `start`, and this block drives an LED.
- Timing is expressed in units of DOT_TICKS clock cycles:
  - dot = 1 unit on, dash = 3 units on;
  - inter-symbol gap = 1 unit off, letter gap = 3 units off.

---
 rtl/morse_pkg.sv | 16 +
 rtl/morse_unit_timer.sv | 30 +++
 rtl/morse_tx.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// Shared types and timing constants for the Morse transmitter.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2,
    LGAP  = 2'd3
  } morse_state_t;

  localparam int unsigned DOT_UNITS        = 1;
  localparam int unsigned DASH_UNITS       = 3;
  localparam int unsigned SYM_GAP_UNITS    = 1;
  localparam int unsigned LETTER_GAP_UNITS = 3;

endpackage

// File: rtl/morse_unit_timer.sv
// Loadable down-counter; expire is high on the last cycle of the loaded duration.
module morse_unit_timer #(
  parameter int unsigned W = 4
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  // cnt holds the cycles remaining including the current one; expire tracks cnt==1
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt    <= '0;
      expire <= 1'b0;
    end else if (load) begin
      cnt    <= load_val;
      expire <= (load_val == W'(1));
    end else if (cnt != '0) begin
      cnt    <= cnt - W'(1);
      expire <= (cnt == W'(2));
    end else begin
      expire <= 1'b0;
    end
  end

endmodule

// File: rtl/morse_tx.sv
// Morse letter transmitter: blinks lightOn with dot/dash/gap timing in DOT_TICKS units.
// Optional MORSE_REPEAT_EN adds an rpt input that restarts the same letter after the letter gap.
module morse_tx
  import morse_pkg::*;
#(
  parameter int unsigned DOT_TICKS = 4,
  parameter int unsigned MAX_SYMS  = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                start,
  input  logic [2:0]          length,
  input  logic [MAX_SYMS-1:0] pattern,
`ifdef MORSE_REPEAT_EN
  input  logic                rpt,
`endif
  output logic                lightOn,
  output logic                busy,
  output logic                done
);

  localparam int unsigned TW = $clog2(3 * DOT_TICKS + 1);
  localparam int unsigned SW = (MAX_SYMS > 1) ? $clog2(MAX_SYMS) : 1;

  localparam logic [TW-1:0] T_DOT  = TW'(DOT_UNITS * DOT_TICKS);
  localparam logic [TW-1:0] T_DASH = TW'(DASH_UNITS * DOT_TICKS);
  localparam logic [TW-1:0] T_SGAP = TW'(SYM_GAP_UNITS * DOT_TICKS);
  localparam logic [TW-1:0] T_LGAP = TW'(LETTER_GAP_UNITS * DOT_TICKS);

  morse_state_t        state;
  logic [SW-1:0]       idx;
  logic [2:0]          len_q;
  logic [MAX_SYMS-1:0] pat_q;

  logic          expire;
  logic          accept_c;
  logic          last_c;
  logic          rpt_c;
  logic          load_c;
  logic [TW-1:0] load_val_c;

`ifdef MORSE_REPEAT_EN
  assign rpt_c = rpt;
`else
  assign rpt_c = 1'b0;
`endif

  function automatic logic [TW-1:0] mark_ticks(input logic dash);
    return dash ? T_DASH : T_DOT;
  endfunction

  // Timer reload requests, issued on the same edge as the phase change
  always_comb begin
    accept_c   = (state == IDLE) && start && (length != 3'd0) && (32'(length) <= MAX_SYMS);
    last_c     = (32'(idx) + 32'd1 >= 32'(len_q));
    load_c     = 1'b0;
    load_val_c = '0;
    case (state)
      IDLE: begin
        if (accept_c) begin
          load_c     = 1'b1;
          load_val_c = mark_ticks(pattern[0]);
        end
      end
      MARK: begin
        if (expire) begin
          load_c     = 1'b1;
          load_val_c = last_c ? T_LGAP : T_SGAP;
        end
      end
      SPACE: begin
        if (expire) begin
          load_c     = 1'b1;
          load_val_c = mark_ticks(pat_q[idx]);
        end
      end
      LGAP: begin
        if (expire && rpt_c) begin
          load_c     = 1'b1;
          load_val_c = mark_ticks(pat_q[0]);
        end
      end
      default: begin
        load_c     = 1'b0;
        load_val_c = '0;
      end
    endcase
  end

  morse_unit_timer #(.W(TW)) u_timer (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (load_c),
    .load_val (load_val_c),
    .expire   (expire)
  );

  // Phase sequencing with registered Moore outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      idx     <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      lightOn <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            len_q   <= length;
            pat_q   <= pattern;
            idx     <= '0;
            state   <= MARK;
            lightOn <= 1'b1;
            busy    <= 1'b1;
          end
        end
        MARK: begin
          if (expire) begin
            lightOn <= 1'b0;
            if (last_c) begin
              state <= LGAP;
            end else begin
              state <= SPACE;
              idx   <= idx + SW'(1);
            end
          end
        end
        SPACE: begin
          if (expire) begin
            state   <= MARK;
            lightOn <= 1'b1;
          end
        end
        LGAP: begin
          if (expire) begin
            done <= 1'b1;
            if (rpt_c) begin
              state   <= MARK;
              idx     <= '0;
              lightOn <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          lightOn <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
